fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, 2-entry {pc, insn} skid FIFO toward decode,
// redirect handling and a sticky halt on misaligned redirect targets.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h01000000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_address,
    output logic        imem_read_write,
    input  logic [31:0] imem_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        f_valid,
    input  logic        f_ready,
    output logic [31:0] f_pc,
    output logic [31:0] f_insn,
    output logic        f_misaligned
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned DEPTH = 2;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    w_pc_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               r_head;
    logic               w_head_nxt;
    logic               r_misaligned;
    logic               w_misaligned_nxt;
    logic [XLEN-1:0]    r_fifo_pc   [DEPTH];
    logic [XLEN-1:0]    r_fifo_insn [DEPTH];

    logic               w_deq;
    logic               w_enq;
    logic               w_redirect;
    logic               w_bad_target;
    logic               w_tail;

    assign w_deq        = (r_count != CNT_W'(0)) && f_ready;
    assign w_redirect   = redirect_valid && (r_state != HALT);
    assign w_bad_target = w_redirect && (redirect_pc[1:0] != 2'b00);
    assign w_enq        = (r_state == FETCH) && !redirect_valid
                          && ((r_count < CNT_W'(2)) || w_deq);
    // With count==2 the tail aliases the head, which is retired in the same cycle.
    assign w_tail       = r_head ^ r_count[0];

    // Next-state logic for control state, PC, FIFO pointers and the sticky flag.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_count_nxt      = r_count;
        w_head_nxt       = r_head;
        w_misaligned_nxt = r_misaligned;

        case (r_state)
            BOOT:    w_state_nxt = FETCH;
            FETCH:   w_state_nxt = FETCH;
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = BOOT;
        endcase

        if (w_redirect) begin
            w_count_nxt = CNT_W'(0);
            w_head_nxt  = 1'b0;
            if (w_bad_target) begin
                w_misaligned_nxt = 1'b1;
                w_state_nxt      = HALT;
            end else begin
                w_pc_nxt = redirect_pc;
            end
        end else begin
            w_head_nxt  = r_head ^ w_deq;
            w_count_nxt = CNT_W'(r_count + CNT_W'(w_enq) - CNT_W'(w_deq));
            if (w_enq) begin
                w_pc_nxt = XLEN'(r_pc + XLEN'(4));
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_count      <= CNT_W'(0);
            r_head       <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_count      <= w_count_nxt;
            r_head       <= w_head_nxt;
            r_misaligned <= w_misaligned_nxt;
        end
    end

    // FIFO payload storage; occupancy is tracked by r_count so no reset is needed.
    always_ff @(posedge clock) begin
        if (reset && w_enq) begin
            r_fifo_pc[w_tail]   <= r_pc;
            r_fifo_insn[w_tail] <= imem_data_out;
        end
    end

    assign imem_address    = r_pc;
    assign imem_read_write = 1'b0;
    assign f_valid         = (r_count != CNT_W'(0));
    assign f_pc            = r_fifo_pc[r_head];
    assign f_insn          = r_fifo_insn[r_head];
    assign f_misaligned    = r_misaligned;

endmodule
